// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch sequencer (master) and a synchronous ROM (slave).
interface fetch_unit_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_en;
  logic [IW-1:0]   imem_rdata;

  modport master (output imem_addr, output imem_en, input  imem_rdata);
  modport slave  (input  imem_addr, input  imem_en, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, streams one ROM word per cycle, squashes on redirect, stops on halt.
// Optional FETCH_PERF_EN adds saturating retired/bubble counters.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              IW       = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0]      HALT_OP  = 6'h3F
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    imem,
  output logic [IW-1:0]   instr,
  output logic [5:0]      op,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc_out,
  input  logic            stall,
  input  logic            PcSrc,
  input  logic            Jump,
  input  logic [PC_W-1:0] target,
`ifdef FETCH_PERF_EN
  output logic [15:0]     retired_cnt,
  output logic [15:0]     bubble_cnt,
`endif
  output logic            halted
);

  typedef enum logic [1:0] {FILL, RUN, REDIRECT, HALT} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            en;
  logic            hold;

  assign instr = imem.imem_rdata;
  assign op    = instr[IW-1 -: 6];

  // A stalled live instruction freezes the ROM output so instr stays put.
  assign hold = (state_q == RUN) && valid_q && stall;
  assign en   = !(hold || (state_q == HALT));

  assign imem.imem_addr = addr_q;
  assign imem.imem_en   = en;
  assign instr_valid    = valid_q;
  assign pc_out         = pc_q;
  assign halted         = halted_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    pc_d     = en ? addr_q : pc_q;
    case (state_q)
      FILL: begin
        addr_d  = RESET_PC + PC_W'(1);
        valid_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (hold) begin
          // hold everything
        end else if (valid_q && (op == HALT_OP)) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (PcSrc || Jump) begin
          // The word fetched this edge is the fall-through; mark it dead.
          addr_d  = target;
          valid_d = 1'b0;
          state_d = REDIRECT;
        end else begin
          addr_d  = addr_q + PC_W'(1);
          valid_d = 1'b1;
        end
      end
      REDIRECT: begin
        addr_d  = addr_q + PC_W'(1);
        valid_d = 1'b1;
        state_d = RUN;
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      addr_q   <= RESET_PC;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] bubble_q, bubble_d;

  always_comb begin
    retired_d = retired_q;
    bubble_d  = bubble_q;
    if (valid_q && !stall && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
    if ((state_q == REDIRECT) && (bubble_q != 16'hFFFF)) bubble_d = bubble_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      bubble_q  <= '0;
    end else begin
      retired_q <= retired_d;
      bubble_q  <= bubble_d;
    end
  end

  assign retired_cnt = retired_q;
  assign bubble_cnt  = bubble_q;
`endif

endmodule
